// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BHT of saturating counters plus tagged BTB for IF-stage prediction
// Combinational lookup from if_pc_i; trains on resolved branches/jumps reported by ID.
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [XLEN-1:0]   if_pc_i,
  output logic              pred_hit_o,
  output logic              pred_taken_o,
  output logic [XLEN-1:0]   pred_target_o,
  input  logic              upd_valid_i,
  input  logic [XLEN-1:0]   upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [XLEN-1:0]   upd_target_i,
  input  logic              upd_is_jump_i,
  input  logic              upd_pred_taken_i,
  input  logic [XLEN-1:0]   upd_pred_target_i,
  input  logic              clr_stats_i,
  output logic              mispredict_o,
  output logic [STAT_W-1:0] branch_cnt_o,
  output logic [STAT_W-1:0] mispred_cnt_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1 << (CTR_W - 1));
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic              valid_q  [ENTRIES];
  logic              valid_d  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [TAG_W-1:0]  tag_d    [ENTRIES];
  logic [XLEN-1:0]   target_q [ENTRIES];
  logic [XLEN-1:0]   target_d [ENTRIES];
  logic [CTR_W-1:0]  ctr_q    [ENTRIES];
  logic [CTR_W-1:0]  ctr_d    [ENTRIES];

  logic              mispredict_q, mispredict_d;
  logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [STAT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0]  if_idx, upd_idx;
  logic [TAG_W-1:0]  if_tag, upd_tag;
  logic              upd_hit;
  logic              mis;
  logic              unused_upd_pc;

  assign if_idx  = if_pc_i[IDX_W+1:2];
  assign if_tag  = if_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx = upd_pc_i[IDX_W+1:2];
  assign upd_tag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign unused_upd_pc = ^upd_pc_i;

  assign pred_hit_o    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken_o  = pred_hit_o && ctr_q[if_idx][CTR_W-1];
  assign pred_target_o = pred_taken_o ? target_q[if_idx] : if_pc_i + XLEN'(4);

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign mis     = (upd_pred_taken_i != upd_taken_i) ||
                   (upd_taken_i && (upd_pred_target_i != upd_target_i));

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (upd_valid_i) begin
      if (upd_hit) begin
        if (upd_is_jump_i) begin
          ctr_d[upd_idx]    = CTR_MAX;
          target_d[upd_idx] = upd_target_i;
        end else if (upd_taken_i) begin
          if (ctr_q[upd_idx] != CTR_MAX) ctr_d[upd_idx] = ctr_q[upd_idx] + CTR_W'(1);
          target_d[upd_idx] = upd_target_i;
        end else if (ctr_q[upd_idx] != '0) begin
          ctr_d[upd_idx] = ctr_q[upd_idx] - CTR_W'(1);
        end
      end else if (upd_taken_i || upd_is_jump_i) begin
        // Allocation evicts whatever aliased into this index.
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target_i;
        ctr_d[upd_idx]    = upd_is_jump_i ? CTR_MAX : CTR_WEAK;
      end
    end
  end

  always_comb begin
    mispredict_d  = upd_valid_i && mis;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (clr_stats_i) begin
      branch_cnt_d  = '0;
      mispred_cnt_d = '0;
    end else if (upd_valid_i) begin
      if (branch_cnt_q != STAT_MAX) branch_cnt_d = branch_cnt_q + STAT_W'(1);
      if (mis && (mispred_cnt_q != STAT_MAX)) mispred_cnt_d = mispred_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= '0;
      end
      mispredict_q  <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      target_q      <= target_d;
      ctr_q         <= ctr_d;
      mispredict_q  <= mispredict_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign mispredict_o  = mispredict_q;
  assign branch_cnt_o  = branch_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed table, saturation, reset and random checks against a reference model
module tb_branch_predictor;

  localparam int STAT_MAX = 15;

  logic        clk_i, rst_i;
  logic [31:0] if_pc_i;
  logic        pred_hit_o, pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i, upd_taken_i, upd_is_jump_i, upd_pred_taken_i, clr_stats_i;
  logic [31:0] upd_pc_i, upd_target_i, upd_pred_target_i;
  logic        mispredict_o;
  logic [3:0]  branch_cnt_o, mispred_cnt_o;

  branch_predictor #(.XLEN(32), .ENTRIES(64), .TAG_W(8), .CTR_W(2), .STAT_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .if_pc_i(if_pc_i),
    .pred_hit_o(pred_hit_o), .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
    .upd_target_i(upd_target_i), .upd_is_jump_i(upd_is_jump_i),
    .upd_pred_taken_i(upd_pred_taken_i), .upd_pred_target_i(upd_pred_target_i),
    .clr_stats_i(clr_stats_i), .mispredict_o(mispredict_o),
    .branch_cnt_o(branch_cnt_o), .mispred_cnt_o(mispred_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] if_pc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        uj;
    logic        upt;
    logic [31:0] uptgt;
    logic        clr;
    logic        chk;
    logic        eh;
    logic        et;
    logic [31:0] etgt;
    logic        emis;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one record per table slot, counters as plain integers.
  bit          m_valid [64];
  int unsigned m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_ctr   [64];
  int          m_bcnt, m_mcnt;
  bit          m_mis;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
    end
    m_bcnt = 0; m_mcnt = 0; m_mis = 0;
  endtask

  task automatic model_lookup(input logic [31:0] pc, output logic h, output logic t,
                              output logic [31:0] tg);
    int unsigned i, tag;
    i   = (pc / 4) % 64;
    tag = (pc / 256) % 256;
    h   = m_valid[i] && (m_tag[i] == tag);
    t   = h && (m_ctr[i] >= 2);
    tg  = t ? m_tgt[i] : pc + 32'd4;
  endtask

  task automatic model_update(input vec_t v);
    int unsigned i, tag;
    bit hit, mis;
    i   = (v.upc / 4) % 64;
    tag = (v.upc / 256) % 256;
    hit = m_valid[i] && (m_tag[i] == tag);
    mis = (v.upt != v.ut) || (v.ut && (v.uptgt != v.utgt));
    m_mis = v.uv && mis;
    if (v.clr) begin
      m_bcnt = 0; m_mcnt = 0;
    end else if (v.uv) begin
      if (m_bcnt < STAT_MAX) m_bcnt++;
      if (mis && m_mcnt < STAT_MAX) m_mcnt++;
    end
    if (v.uv) begin
      if (hit) begin
        if (v.uj) begin
          m_ctr[i] = 3; m_tgt[i] = v.utgt;
        end else if (v.ut) begin
          m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1; m_tgt[i] = v.utgt;
        end else begin
          m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (v.ut || v.uj) begin
        m_valid[i] = 1; m_tag[i] = tag; m_tgt[i] = v.utgt; m_ctr[i] = v.uj ? 3 : 2;
      end
    end
  endtask

  task automatic check_lookup(input string name);
    logic h, t;
    logic [31:0] tg;
    model_lookup(if_pc_i, h, t, tg);
    check({name, ".hit"}, 32'(pred_hit_o), 32'(h));
    check({name, ".taken"}, 32'(pred_taken_o), 32'(t));
    check({name, ".target"}, pred_target_o, tg);
  endtask

  task automatic check_regs(input string name);
    check({name, ".mispredict"}, 32'(mispredict_o), 32'(m_mis));
    check({name, ".branch_cnt"}, 32'(branch_cnt_o), 32'(m_bcnt));
    check({name, ".mispred_cnt"}, 32'(mispred_cnt_o), 32'(m_mcnt));
  endtask

  task automatic drive(input vec_t v);
    if_pc_i = v.if_pc; upd_valid_i = v.uv; upd_pc_i = v.upc; upd_taken_i = v.ut;
    upd_target_i = v.utgt; upd_is_jump_i = v.uj; upd_pred_taken_i = v.upt;
    upd_pred_target_i = v.uptgt; clr_stats_i = v.clr;
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input vec_t v, input string name);
    drive(v);
    #1;
    check_lookup({name, ".pre"});
    @(posedge clk_i);
    #1;
    model_update(v);
    check_regs(name);
    check_lookup({name, ".post"});
    if (v.chk) begin
      check({name, ".exp_hit"}, 32'(pred_hit_o), 32'(v.eh));
      check({name, ".exp_taken"}, 32'(pred_taken_o), 32'(v.et));
      check({name, ".exp_target"}, pred_target_o, v.etgt);
      check({name, ".exp_mis"}, 32'(mispredict_o), 32'(v.emis));
    end
    @(negedge clk_i);
  endtask

  function automatic vec_t mk(input logic [31:0] if_pc, input logic uv, input logic [31:0] upc,
                              input logic ut, input logic [31:0] utgt, input logic uj,
                              input logic upt, input logic [31:0] uptgt, input logic clr,
                              input logic chk, input logic eh, input logic et,
                              input logic [31:0] etgt, input logic emis);
    vec_t v;
    v.if_pc = if_pc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.uj = uj;
    v.upt = upt; v.uptgt = uptgt; v.clr = clr; v.chk = chk; v.eh = eh; v.et = et;
    v.etgt = etgt; v.emis = emis;
    return v;
  endfunction

  function automatic logic [31:0] rnd_pc();
    logic [31:0] pc;
    pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2) |
         32'($urandom_range(0, 3));
    if ($urandom_range(0, 3) == 0) pc = pc | ($urandom & 32'hFFFF_0000);
    return pc;
  endfunction

  function automatic vec_t rnd_vec();
    vec_t v;
    v.if_pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : rnd_pc();
    v.uv    = ($urandom_range(0, 3) != 0);
    v.upc   = rnd_pc();
    v.ut    = 1'($urandom_range(0, 1));
    v.utgt  = 32'($urandom_range(0, 3)) << 6;
    v.uj    = ($urandom_range(0, 5) == 0);
    v.upt   = 1'($urandom_range(0, 1));
    v.uptgt = $urandom_range(0, 1) ? v.utgt : (32'($urandom_range(0, 3)) << 6);
    v.clr   = ($urandom_range(0, 15) == 0);
    v.chk = 0; v.eh = 0; v.et = 0; v.etgt = 0; v.emis = 0;
    return v;
  endfunction

  initial begin
    vec_t v;
    rst_i = 1'b0;
    drive(mk(32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    model_reset();
    #3;
    check("reset.hit", 32'(pred_hit_o), 32'd0);
    check("reset.taken", 32'(pred_taken_o), 32'd0);
    check("reset.target", pred_target_o, 32'h104);
    check("reset.mispredict", 32'(mispredict_o), 32'd0);
    check("reset.branch_cnt", 32'(branch_cnt_o), 32'd0);
    check("reset.mispred_cnt", 32'(mispred_cnt_o), 32'd0);
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    @(negedge clk_i);

    //          if_pc         uv upc     ut utgt   uj upt uptgt  clr chk eh et etgt          emis
    tbl.push_back(mk(32'h100, 1, 32'h100, 1, 32'h80, 0, 0, 32'h0,  0, 1, 1, 1, 32'h80,  1));
    tbl.push_back(mk(32'h100, 1, 32'h100, 1, 32'h80, 0, 1, 32'h80, 0, 1, 1, 1, 32'h80,  0));
    tbl.push_back(mk(32'h100, 1, 32'h100, 1, 32'h80, 0, 1, 32'h80, 0, 1, 1, 1, 32'h80,  0));
    tbl.push_back(mk(32'h100, 1, 32'h100, 0, 32'h0,  0, 1, 32'h80, 0, 1, 1, 1, 32'h80,  1));
    tbl.push_back(mk(32'h100, 1, 32'h100, 0, 32'h0,  0, 1, 32'h80, 0, 1, 1, 0, 32'h104, 1));
    tbl.push_back(mk(32'h100, 1, 32'h100, 0, 32'h0,  0, 0, 32'h0,  0, 1, 1, 0, 32'h104, 0));
    tbl.push_back(mk(32'h100, 1, 32'h100, 0, 32'h0,  0, 0, 32'h0,  0, 1, 1, 0, 32'h104, 0));
    tbl.push_back(mk(32'h100, 1, 32'h100, 0, 32'h0,  0, 0, 32'h0,  0, 1, 1, 0, 32'h104, 0));
    tbl.push_back(mk(32'h100, 1, 32'h100, 1, 32'h80, 0, 0, 32'h0,  0, 1, 1, 0, 32'h104, 1));
    tbl.push_back(mk(32'h200, 0, 32'h0,   0, 32'h0,  0, 0, 32'h0,  0, 1, 0, 0, 32'h204, 0));
    tbl.push_back(mk(32'h200, 1, 32'h200, 1, 32'h40, 0, 0, 32'h0,  0, 1, 1, 1, 32'h40,  1));
    tbl.push_back(mk(32'h100, 0, 32'h0,   0, 32'h0,  0, 0, 32'h0,  0, 1, 0, 0, 32'h104, 0));
    tbl.push_back(mk(32'h300, 1, 32'h300, 0, 32'h0,  0, 0, 32'h0,  0, 1, 0, 0, 32'h304, 0));
    tbl.push_back(mk(32'h200, 0, 32'h0,   0, 32'h0,  0, 0, 32'h0,  0, 1, 1, 1, 32'h40,  0));
    tbl.push_back(mk(32'h200, 1, 32'h200, 1, 32'h44, 0, 1, 32'h40, 0, 1, 1, 1, 32'h44,  1));
    tbl.push_back(mk(32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 0, 0, 32'h0, 0));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("tbl%0d", i));

    // Statistics saturation and clear-over-increment priority.
    step(mk(32'h300, 1, 32'h300, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0), "clr0");
    check("clr0.branch_zero", 32'(branch_cnt_o), 32'd0);
    for (int i = 0; i < 17; i++)
      step(mk(32'h300, 1, 32'h300, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), $sformatf("sat%0d", i));
    check("sat.branch_cnt", 32'(branch_cnt_o), 32'd15);
    check("sat.mispred_cnt", 32'(mispred_cnt_o), 32'd15);
    step(mk(32'h300, 1, 32'h300, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0), "clr1");
    check("clr1.branch_cnt", 32'(branch_cnt_o), 32'd0);
    check("clr1.mispred_cnt", 32'(mispred_cnt_o), 32'd0);
    check("clr1.mispredict", 32'(mispredict_o), 32'd1);

    for (int i = 0; i < 400; i++) step(rnd_vec(), $sformatf("rnd%0d", i));

    // Jump allocation, then an asynchronous reset between edges.
    step(mk(32'h10, 1, 32'h10, 1, 32'h500, 1, 0, 0, 0, 1, 1, 1, 32'h500, 1), "jump");
    v = mk(32'h10, 1, 32'h20, 1, 32'h600, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(v);
    #2 rst_i = 1'b0;
    model_reset();
    #1;
    check("areset.hit", 32'(pred_hit_o), 32'd0);
    check("areset.target", pred_target_o, 32'h14);
    check("areset.branch_cnt", 32'(branch_cnt_o), 32'd0);
    check("areset.mispred_cnt", 32'(mispred_cnt_o), 32'd0);
    check("areset.mispredict", 32'(mispredict_o), 32'd0);
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    if_pc_i = 32'h20;
    #1;
    check("areset.discard_hit", 32'(pred_hit_o), 32'd0);
    @(posedge clk_i);
    #1;
    model_update(v);
    check_regs("retrain");
    check_lookup("retrain");
    check("retrain.hit", 32'(pred_hit_o), 32'd1);
    check("retrain.target", pred_target_o, 32'h600);
    @(negedge clk_i);
    drive(mk(32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
